ksa32_block_accumulator: RTL and testbench
==========================================

Name: ksa32_block_accumulator

Overview:
Block accumulator that sits around the 32-bit Kogge-Stone adder (KSA32_top). Upstream, it drives the adder's A input from its accumulator register and B from the incoming sample. Downstream, it registers SUM/COUT/overflow back into the accumulator. It consumes a valid/ready stream of 32-bit samples, sums up to MAX_LEN samples per block, then emits the block total with sticky carry/overflow flags over a valid/ready output handshake.

Parameters:
MAX_LEN, 256, maximum samples per block; block closes automatically when the count reaches it (legal range 1..65535).
CNT_W, $clog2(MAX_LEN+1), localparam, width of the sample counter.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  sample valid.
in_ready  out  1  accumulator can accept a sample.
in_data  in  32  sample (two's complement or unsigned, both flags reported).
in_last  in  1  sample closes the current block.
out_valid  out  1  block result valid.
out_ready  in  1  consumer accepts result.
out_sum  out  32  block total (SUM of final add).
out_count  out  CNT_W  samples in block (1..MAX_LEN).
out_cout  out  1  sticky OR of adder COUT over block (unsigned wrap).
out_ovf  out  1  sticky OR of adder overflow over block (signed overflow).

Behaviour:
- Reset (async assert, sync release): state=ACCUM, acc=0, count=0, sticky flags=0. Outputs in_ready=1, out_valid=0, out_sum=0, out_count=0, out_cout=0, out_ovf=0.
- Adder hookup: B=in_data. A=acc when count!=0, A=32'h0 when count==0, so the first sample of a block starts from zero. COUT and overflow are used exactly as the adder produces them.
- State ACCUM: in_ready=1, out_valid=0. On in_valid&in_ready:
  - acc<=SUM, count<=count+1.
  - cout_sticky|=COUT, ovf_sticky|=overflow.
  - On the first beat, the sticky flags load the current flags rather than OR into them.
- Block close: occurs when in_last=1 or count+1==MAX_LEN on the accepted beat.
  - out_sum, out_count, out_cout, out_ovf are loaded from the post-update values.
  - State goes to EMIT.
  - Latency: result is visible the cycle after the closing beat.
- State EMIT: in_ready=0, out_valid=1, outputs held stable. On out_ready:
  - state goes to ACCUM, count=0, sticky flags=0.
  - in_ready rises the next cycle. There is no same-cycle accept of a new sample during EMIT (one bubble per block).
- in_valid with no handshake: acc, count and flags are unchanged.
- MAX_LEN=1: every accepted sample closes a block, giving out_sum=in_data and out_count=1.
- Wrap-around: without the optional feature, acc wraps modulo 2^32 and the flags record the events.
- Reset mid-block: partial sum is discarded. Reset during EMIT: the result is discarded and out_valid drops asynchronously.
- The out_* registers hold their last value after the EMIT handshake. out_valid alone qualifies them.

Optional Feature:
Macro KSA_ACC_SAT_EN.
- Defined: signed saturation. On any beat with overflow=1, acc<=32'h7FFFFFFF if in_data[31]==0, else 32'h80000000. ovf_sticky is still set. COUT handling is unchanged.
- Undefined: acc<=SUM (wrap). No saturation logic is synthesised.

Decomposition:
- Package ksa_acc_pkg: state enum {ACCUM, EMIT}, SAT_POS=32'h7FFFFFFF, SAT_NEG=32'h80000000, default MAX_LEN.
- Sub-module: the existing KSA32_top, instantiated once. The FSM and registers stay in one module; no further sub-module is warranted.

Test Plan:
1. Sample sequence:
   - Stimulus: samples 5, 7, 9 with in_last on the 9.
   - Response: one cycle later out_valid=1, out_sum=21, out_count=3, out_cout=0, out_ovf=0. in_ready=0 until out_ready.
2. Signed overflow:
   - Stimulus: 32'h7FFFFFFF, then 1 with last.
   - Response without SAT: out_sum=32'h80000000, out_ovf=1, out_cout=0. With KSA_ACC_SAT_EN: out_sum=32'h7FFFFFFF, out_ovf=1.
3. Unsigned wrap:
   - Stimulus: 32'hFFFFFFFF, then 2 with last.
   - Response: out_sum=1, out_cout=1, out_ovf=0. Next block {3 last} gives out_sum=3 with flags 0, confirming sticky clear and zero restart.
4. Auto-close:
   - Stimulus: MAX_LEN=4, eight samples of 1 with no in_last, out_ready held 1.
   - Response: two results, each out_sum=4 and out_count=4, with one in_ready bubble between blocks.
5. Backpressure:
   - Stimulus: hold out_ready=0 for 10 cycles in EMIT, with in_valid=1 throughout.
   - Response: outputs stable, in_ready=0, no sample consumed. Release gives out_valid low the next cycle.
6. Reset mid-block:
   - Stimulus: assert rst_n=0 after samples 100 and 200, release, then send {1 last}.
   - Response: out_sum=1, out_count=1.

Source files
------------

// File: rtl/ksa_acc_pkg.sv
// ---------------------------------------------------------------------------
// ksa_acc_pkg
// Shared definitions for the KSA32 block accumulator:
//   acc_state_e  - accumulator FSM states (ACCUM, EMIT)
//   SAT_POS/NEG  - signed saturation limits, used only when KSA_ACC_SAT_EN
//                  is defined
//   DEF_MAX_LEN  - default maximum block length
// ---------------------------------------------------------------------------
package ksa_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } acc_state_e;

    localparam logic [31:0] SAT_POS     = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG     = 32'h8000_0000;
    localparam int          DEF_MAX_LEN = 256;

endpackage

// File: rtl/ksa32_block_accumulator_if.sv
// ---------------------------------------------------------------------------
// ksa32_block_accumulator_if
// Sample stream in, block result out.
//   in_valid/in_ready/in_data/in_last        : sample stream
//   out_valid/out_ready                      : result handshake
//   out_sum/out_count/out_cout/out_ovf       : block result
// master = producer/consumer side, slave = accumulator side.
// CNT_W must equal $clog2(MAX_LEN+1) of the attached accumulator.
// ---------------------------------------------------------------------------
interface ksa32_block_accumulator_if #(
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_cout, out_ovf
    );
endinterface

// File: rtl/KSA32_top.sv
// ---------------------------------------------------------------------------
// KSA32_top
// 32-bit Kogge-Stone adder, carry-in fixed at 0.
//   a, b      in  32  operands
//   sum       out 32  a + b modulo 2^32
//   cout      out 1   carry out of bit 31 (unsigned wrap)
//   overflow  out 1   two's complement overflow
// ---------------------------------------------------------------------------
module KSA32_top (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);
    // g[k]/p[k]: group generate/propagate after k prefix levels
    logic [31:0] g [0:5];
    logic [31:0] p [0:4];

    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << k)) begin
                    g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
                end else begin
                    g[k+1][i] = g[k][i];
                end
            end
            if (k < 4) begin
                for (int i = 0; i < 32; i++) begin
                    if (i >= (1 << k)) begin
                        p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
                    end else begin
                        p[k+1][i] = p[k][i];
                    end
                end
            end
        end
    end

    // g[5][i] is the carry into bit i+1
    assign sum      = p[0] ^ {g[5][30:0], 1'b0};
    assign cout     = g[5][31];
    assign overflow = g[5][31] ^ g[5][30];

endmodule

// File: rtl/ksa32_block_accumulator.sv
// ---------------------------------------------------------------------------
// ksa32_block_accumulator
// Sums up to MAX_LEN 32-bit samples per block through KSA32_top and emits
// the block total with sticky carry/overflow flags.
//   clk    in  1   clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave modport of ksa32_block_accumulator_if (sample stream in,
//          block result out)
// Optional build macro KSA_ACC_SAT_EN: signed saturation of the accumulator
// on overflow instead of modulo-2^32 wrap.
//
// state | meaning
// ------+---------------------------------------------------
// ACCUM | accepting samples into the running block
// EMIT  | block result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module ksa32_block_accumulator
    import ksa_acc_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic clk,
    input  logic rst_n,
    ksa32_block_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_LIM = CNT_W'(MAX_LEN);

    localparam logic [0:0] ST_ACCUM = ACCUM;
    localparam logic [0:0] ST_EMIT  = EMIT;

    logic [0:0]       state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] count;
    logic             cout_sticky;
    logic             ovf_sticky;

    logic [31:0]      res_sum;
    logic [CNT_W-1:0] res_count;
    logic             res_cout;
    logic             res_ovf;

    logic [31:0]      add_a;
    logic [31:0]      add_sum;
    logic             add_cout;
    logic             add_ovf;

    logic             beat;
    logic             first;
    logic             close;
    logic [CNT_W-1:0] count_nxt;
    logic [31:0]      acc_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;

    // The first sample of a block starts from zero, so acc needs no clear.
    assign first = (count == '0);
    assign add_a = first ? 32'h0 : acc;

    KSA32_top u_ksa (
        .a        (add_a),
        .b        (bus.in_data),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    assign beat      = bus.in_valid && (state == ST_ACCUM);
    assign count_nxt = count + 1'b1;
    assign close     = bus.in_last || (count_nxt == LEN_LIM);
    assign cout_nxt  = first ? add_cout : (cout_sticky | add_cout);
    assign ovf_nxt   = first ? add_ovf  : (ovf_sticky  | add_ovf);

`ifdef KSA_ACC_SAT_EN
    assign acc_nxt = add_ovf ? (bus.in_data[31] ? SAT_NEG : SAT_POS) : add_sum;
`else
    assign acc_nxt = add_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ACCUM;
            acc         <= '0;
            count       <= '0;
            cout_sticky <= 1'b0;
            ovf_sticky  <= 1'b0;
            res_sum     <= '0;
            res_count   <= '0;
            res_cout    <= 1'b0;
            res_ovf     <= 1'b0;
        end else if (state == ST_ACCUM) begin
            if (beat) begin
                acc         <= acc_nxt;
                count       <= count_nxt;
                cout_sticky <= cout_nxt;
                ovf_sticky  <= ovf_nxt;
                if (close) begin
                    res_sum   <= acc_nxt;
                    res_count <= count_nxt;
                    res_cout  <= cout_nxt;
                    res_ovf   <= ovf_nxt;
                    state     <= ST_EMIT;
                end
            end
        end else begin
            if (bus.out_ready) begin
                state       <= ST_ACCUM;
                count       <= '0;
                cout_sticky <= 1'b0;
                ovf_sticky  <= 1'b0;
            end
        end
    end

    // Handshake outputs decode state directly so reset drops out_valid at once.
    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = (state == ST_EMIT);
    assign bus.out_sum   = res_sum;
    assign bus.out_count = res_count;
    assign bus.out_cout  = res_cout;
    assign bus.out_ovf   = res_ovf;

endmodule

// File: tb/tb_ksa32_block_accumulator.sv
module tb_ksa32_block_accumulator;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] cnt;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    ksa32_block_accumulator_if #(.CNT_W(CNT_W)) bus ();

    ksa32_block_accumulator #(.MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Block result from plain arithmetic over the samples of one block.
    function automatic res_t model(input logic [31:0] q[$]);
        res_t        r;
        logic [31:0] acc;
        logic [32:0] u;
        longint      s;
        logic        c, o;
        acc = 0;
        r = '0;
        foreach (q[i]) begin
            u = {1'b0, acc} + {1'b0, q[i]};
            s = longint'($signed(acc)) + longint'($signed(q[i]));
            c = u[32];
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            r.cout = r.cout | c;
            r.ovf  = r.ovf | o;
`ifdef KSA_ACC_SAT_EN
            if (o) acc = q[i][31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else   acc = u[31:0];
`else
            acc = u[31:0];
`endif
        end
        r.sum = acc;
        r.cnt = q.size();
        return r;
    endfunction

    task automatic push(input logic [31:0] d, input logic l);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("push_timeout", {63'b0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_block(input string tag, input res_t r, input int delay);
        int t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check({tag, "_timeout"}, {63'b0, bus.out_valid}, 64'd1);
        check({tag, "_sum"},   {32'b0, bus.out_sum}, {32'b0, r.sum});
        check({tag, "_count"}, 64'(bus.out_count), {32'b0, r.cnt});
        check({tag, "_cout"},  {63'b0, bus.out_cout}, {63'b0, r.cout});
        check({tag, "_ovf"},   {63'b0, bus.out_ovf}, {63'b0, r.ovf});
        repeat (delay) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_vld_drop"}, {63'b0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] held_sum;
        logic [31:0] exp_q[$];
        res_t        r;
        int          beats, bubbles, nres, len;
        logic [31:0] d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {63'b0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("rst_out_sum",   {32'b0, bus.out_sum}, 64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_flags",     {62'b0, bus.out_cout, bus.out_ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 5,7,9 with last on 9; result the cycle after the closing beat
        push(32'd5, 1'b0);
        push(32'd7, 1'b0);
        push(32'd9, 1'b1);
        check("t1_latency_vld", {63'b0, bus.out_valid}, 64'd1);
        check("t1_in_ready",    {63'b0, bus.in_ready}, 64'd0);
        q = '{32'd5, 32'd7, 32'd9};
        r = model(q);
        check("t1_model_sum", {32'b0, r.sum}, 64'd21);
        check("t1_sum", {32'b0, bus.out_sum}, 64'd21);
        check("t1_cnt", 64'(bus.out_count), 64'd3);

        // backpressure with in_valid high: nothing consumed, outputs stable
        held_sum = bus.out_sum;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd1000;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
            check("bp_valid",    {63'b0, bus.out_valid}, 64'd1);
            check("bp_sum",      {32'b0, bus.out_sum}, {32'b0, held_sum});
            check("bp_count",    64'(bus.out_count), 64'd3);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_release_vld", {63'b0, bus.out_valid}, 64'd0);
        check("bp_release_rdy", {63'b0, bus.in_ready}, 64'd1);

        // signed overflow
        push(32'h7FFF_FFFF, 1'b0);
        push(32'd1, 1'b1);
        q = '{32'h7FFF_FFFF, 32'd1};
        expect_block("t2", model(q), 0);

        // unsigned wrap, then a fresh block confirms sticky clear
        push(32'hFFFF_FFFF, 1'b0);
        push(32'd2, 1'b1);
        q = '{32'hFFFF_FFFF, 32'd2};
        r = model(q);
        check("t3_model_cout", {63'b0, r.cout}, 64'd1);
        expect_block("t3a", r, 1);
        push(32'd3, 1'b1);
        q = '{32'd3};
        expect_block("t3b", model(q), 0);

        // auto-close at MAX_LEN, out_ready held high
        q = '{32'd1, 32'd1, 32'd1, 32'd1};
        r = model(q);
        beats = 0; bubbles = 0; nres = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'd1;
        bus.in_last   = 1'b0;
        for (int c = 0; c < 40 && nres < 2; c++) begin
            if (bus.out_valid) begin
                check("t4_sum",   {32'b0, bus.out_sum}, {32'b0, r.sum});
                check("t4_count", 64'(bus.out_count), 64'd4);
                nres++;
            end
            if (bus.in_valid && bus.in_ready) beats++;
            else if (bus.in_valid) bubbles++;
            @(negedge clk);
            if (beats == 8) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        check("t4_results", nres, 2);
        check("t4_beats", beats, 8);
        check("t4_bubbles", bubbles, 1);
        @(negedge clk);
        check("t4_idle_vld", {63'b0, bus.out_valid}, 64'd0);

        // reset mid-block discards the partial sum
        push(32'd100, 1'b0);
        push(32'd200, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_rdy", {63'b0, bus.in_ready}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        push(32'd1, 1'b1);
        q = '{32'd1};
        expect_block("t6", model(q), 0);

        // reset during EMIT drops out_valid asynchronously
        push(32'd7, 1'b1);
        check("t7_vld", {63'b0, bus.out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check("t7_async_drop", {63'b0, bus.out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // randomized blocks with idle gaps and random consumer delay
        for (int b = 0; b < 25; b++) begin
            len = $urandom_range(1, MAX_LEN);
            exp_q.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       d = $urandom_range(0, 1000);
                    1:       d = 32'h7FFF_0000 + $urandom_range(0, 65535);
                    2:       d = 32'h8000_0000 + $urandom_range(0, 65535);
                    default: d = $urandom;
                endcase
                exp_q.push_back(d);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                // last on the final sample unless the block fills up anyway
                push(d, (i == len - 1) && (len < MAX_LEN || $urandom_range(0, 1) == 1));
            end
            expect_block("rand", model(exp_q), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
